// File: rtl/rv64g_l1_sram_bank_p_if.sv
// ----------------------------------------------------------------------------
// rv64g_l1_sram_bank_p_if
// Request/response bundle for one L1 SRAM bank.
//   master modport : drives the request fields and flush, observes the response
//   slave  modport : the bank itself
// Request : req_valid_i/req_ready_o handshake, req_op_i, index_i, word_i,
//           way_i, be_i, wdata_i, tag_i, state_i, lookup_tag_i, err_inject_i
// Flush   : flush_i (start invalidate-all walk), flush_busy_o
// Response: rsp_valid_o, hit_o, hit_way_o, rdata_o, state_o, parity_err_o
// ----------------------------------------------------------------------------
interface rv64g_l1_sram_bank_p_if #(
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 53,
    parameter int INDEX_W = 5,
    parameter int WORD_W  = 3,
    parameter int WAY_W   = 3
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [1:0]            req_op_i;
    logic [INDEX_W-1:0]    index_i;
    logic [WORD_W-1:0]     word_i;
    logic [WAY_W-1:0]      way_i;
    logic [DATA_W/8-1:0]   be_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [TAG_W-1:0]      tag_i;
    logic [1:0]            state_i;
    logic [TAG_W-1:0]      lookup_tag_i;
    logic                  err_inject_i;
    logic                  flush_i;
    logic                  flush_busy_o;
    logic                  rsp_valid_o;
    logic                  hit_o;
    logic [WAY_W-1:0]      hit_way_o;
    logic [DATA_W-1:0]     rdata_o;
    logic [1:0]            state_o;
    logic                  parity_err_o;

    modport master (
        output req_valid_i, req_op_i, index_i, word_i, way_i, be_i, wdata_i,
               tag_i, state_i, lookup_tag_i, err_inject_i, flush_i,
        input  req_ready_o, flush_busy_o, rsp_valid_o, hit_o, hit_way_o,
               rdata_o, state_o, parity_err_o
    );

    modport slave (
        input  req_valid_i, req_op_i, index_i, word_i, way_i, be_i, wdata_i,
               tag_i, state_i, lookup_tag_i, err_inject_i, flush_i,
        output req_ready_o, flush_busy_o, rsp_valid_o, hit_o, hit_way_o,
               rdata_o, state_o, parity_err_o
    );
endinterface

// File: rtl/rv64g_l1_sram_bank_p.sv
// ----------------------------------------------------------------------------
// rv64g_l1_sram_bank_p
// One set-associative L1 bank: data, tag and MESI state arrays with a
// single-cycle lookup and an invalidate-all flush walk.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : rv64g_l1_sram_bank_p_if.slave (request, flush and response)
// Ops (req_op_i): 00 lookup, 01 data write, 10 tag+state write,
//                 11 data+tag+state write.
// Optional feature: define L1_SRAM_BANK_PARITY_EN to store one even-parity
// bit per data byte and report mismatches on parity_err_o.
// ----------------------------------------------------------------------------
module rv64g_l1_sram_bank_p #(
    parameter int SETS           = 32,
    parameter int WAYS           = 8,
    parameter int WORDS_PER_LINE = 8,
    parameter int DATA_W         = 64,
    parameter int TAG_W          = 53,
    parameter int INDEX_W        = 5,
    parameter int WORD_W         = 3,
    parameter int WAY_W          = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    rv64g_l1_sram_bank_p_if.slave        bus
);
    localparam int BYTES = DATA_W / 8;
    localparam logic [1:0] MESI_N = 2'b00;

    typedef enum logic {IDLE = 1'b0, WALK = 1'b1} fsm_t;

    // Storage arrays. Only the state array is reset; data and tags are
    // don't-care while their way is invalid.
    logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [1:0]        state_q [WAYS][SETS];

    fsm_t               fsm_q, fsm_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;

    logic               rsp_valid_q;
    logic               hit_q;
    logic [WAY_W-1:0]   hit_way_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         rstate_q;

    logic               ready;
    logic               accept;
    logic               do_lookup;
    logic               do_dwrite;
    logic               do_twrite;
    logic               walking;

    logic               hit_d;
    logic [WAY_W-1:0]   hit_way_d;
    logic [WAY_W-1:0]   sel_way;
    logic [DATA_W-1:0]  rword;

    assign accept    = bus.req_valid_i && ready;
    assign do_lookup = accept && (bus.req_op_i == 2'b00);
    assign do_dwrite = accept && bus.req_op_i[0];
    assign do_twrite = accept && bus.req_op_i[1];

    // ---------------- flush FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- flush FSM: next state ----------------
    // flush_i is only looked at in IDLE, so a repeat pulse mid-walk is ignored.
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (bus.flush_i) begin
                    fsm_d = WALK;
                    cnt_d = '0;
                end
            end
            WALK: begin
                if (cnt_q == INDEX_W'(SETS - 1)) begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // ---------------- flush FSM: outputs ----------------
    always_comb begin
        walking = (fsm_q == WALK);
        ready   = !walking;
    end

    assign bus.flush_busy_o = walking;
    assign bus.req_ready_o  = ready;

    // Lowest-numbered valid way with a matching tag wins.
    always_comb begin
        hit_d     = 1'b0;
        hit_way_d = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if ((state_q[w][bus.index_i] != MESI_N) &&
                (tag_q[w][bus.index_i] == bus.lookup_tag_i)) begin
                hit_d     = 1'b1;
                hit_way_d = WAY_W'(w);
            end
        end
        sel_way = hit_d ? hit_way_d : bus.way_i;
        rword   = data_q[sel_way][bus.index_i][bus.word_i];
    end

    // Data and tag arrays: written only on accepted requests, never reset.
    always_ff @(posedge clk_i) begin
        if (do_dwrite) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.be_i[b]) begin
                    data_q[bus.way_i][bus.index_i][bus.word_i][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
                end
            end
        end
        if (do_twrite) begin
            tag_q[bus.way_i][bus.index_i] <= bus.tag_i;
        end
    end

    // State array: reset to invalid; a walk cycle invalidates every way of
    // one set. Writes and walk never coincide because ready is low in WALK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    state_q[w][s] <= MESI_N;
                end
            end
        end else begin
            if (do_twrite) begin
                state_q[bus.way_i][bus.index_i] <= bus.state_i;
            end
            if (walking) begin
                for (int w = 0; w < WAYS; w++) begin
                    state_q[w][cnt_q] <= MESI_N;
                end
            end
        end
    end

    // ---------------- response stage ----------------
    // Response fields hold until the next accepted lookup.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            rdata_q     <= '0;
            rstate_q    <= MESI_N;
        end else begin
            rsp_valid_q <= do_lookup;
            if (do_lookup) begin
                hit_q     <= hit_d;
                hit_way_q <= sel_way;
                rdata_q   <= rword;
                rstate_q  <= state_q[sel_way][bus.index_i];
            end
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.hit_o       = hit_q;
    assign bus.hit_way_o   = hit_way_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.state_o     = rstate_q;

`ifdef L1_SRAM_BANK_PARITY_EN
    logic [BYTES-1:0] par_q [WAYS][SETS][WORDS_PER_LINE];
    logic [BYTES-1:0] par_rd;
    logic             perr_d;
    logic             perr_q;

    // Even parity: stored bit equals XOR of the byte. Injection flips byte 0's
    // bit whether or not byte 0 is enabled on this write.
    always_ff @(posedge clk_i) begin
        if (do_dwrite) begin
            for (int b = 0; b < BYTES; b++) begin
                if (b == 0) begin
                    par_q[bus.way_i][bus.index_i][bus.word_i][0] <=
                        (bus.be_i[0] ? ^bus.wdata_i[7:0]
                                     : par_q[bus.way_i][bus.index_i][bus.word_i][0])
                        ^ bus.err_inject_i;
                end else if (bus.be_i[b]) begin
                    par_q[bus.way_i][bus.index_i][bus.word_i][b] <= ^bus.wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        par_rd = par_q[sel_way][bus.index_i][bus.word_i];
        perr_d = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            if ((^rword[b*8 +: 8]) != par_rd[b]) begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perr_q <= 1'b0;
        end else if (do_lookup) begin
            perr_q <= perr_d;
        end else begin
            perr_q <= 1'b0;
        end
    end

    assign bus.parity_err_o = perr_q;
`else
    logic unused_err_inject;
    assign unused_err_inject = bus.err_inject_i;
    assign bus.parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rv64g_l1_sram_bank_p.sv
module tb_rv64g_l1_sram_bank_p;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    rv64g_l1_sram_bank_p_if bus ();

    rv64g_l1_sram_bank_p dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = 2'b00;
        bus.index_i      = '0;
        bus.word_i       = '0;
        bus.way_i        = '0;
        bus.be_i         = '0;
        bus.wdata_i      = '0;
        bus.tag_i        = '0;
        bus.state_i      = '0;
        bus.lookup_tag_i = '0;
        bus.err_inject_i = 1'b0;
        bus.flush_i      = 1'b0;
    endtask

    // Drive one request on the falling edge, sample #1 after the rising edge.
    task automatic req(input logic [1:0] op, input logic [4:0] idx, input logic [2:0] wd,
                       input logic [2:0] way, input logic [7:0] be, input logic [63:0] wdat,
                       input logic [52:0] tag, input logic [1:0] st, input logic inj,
                       input logic fl);
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_op_i     = op;
        bus.index_i      = idx;
        bus.word_i       = wd;
        bus.way_i        = way;
        bus.be_i         = be;
        bus.wdata_i      = wdat;
        bus.tag_i        = tag;
        bus.state_i      = st;
        bus.lookup_tag_i = tag;
        bus.err_inject_i = inj;
        bus.flush_i      = fl;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic lookup(input logic [4:0] idx, input logic [2:0] wd,
                          input logic [2:0] way, input logic [52:0] tag);
        req(2'b00, idx, wd, way, 8'h00, 64'h0, tag, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
    endtask

    // Count busy cycles (bounded); optionally re-pulse flush mid-walk.
    task automatic wait_walk(input bit repulse, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.flush_busy_o) break;
            busy_cnt++;
            if (busy_cnt == 2) chk("ready_low_in_walk", 64'(bus.req_ready_o), 64'd0);
            if (repulse && busy_cnt == 5) bus.flush_i = 1'b1;
            @(posedge clk);
            #1;
            bus.flush_i = 1'b0;
        end
    endtask

    int bc;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",      64'(bus.flush_busy_o), 64'd0);
        chk("rst_ready",     64'(bus.req_ready_o),  64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o),  64'd0);
        chk("rst_hit",       64'(bus.hit_o),        64'd0);
        chk("rst_hit_way",   64'(bus.hit_way_o),    64'd0);
        chk("rst_rdata",     bus.rdata_o,           64'd0);
        chk("rst_state",     64'(bus.state_o),      64'd0);
        chk("rst_perr",      64'(bus.parity_err_o), 64'd0);

        // Full write then lookup
        req(2'b11, 5'd3, 3'd5, 3'd6, 8'hFF, 64'h1122334455667788, 53'h1A, 2'b11, 1'b0, 1'b0);
        chk("wr_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
        lookup(5'd3, 3'd5, 3'd0, 53'h1A);
        chk("lk1_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("lk1_hit",   64'(bus.hit_o),       64'd1);
        chk("lk1_way",   64'(bus.hit_way_o),   64'd6);
        chk("lk1_data",  bus.rdata_o,          64'h1122334455667788);
        chk("lk1_state", 64'(bus.state_o),     64'd3);
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", 64'(bus.rsp_valid_o), 64'd0);
        chk("rsp_hold_data", bus.rdata_o,          64'h1122334455667788);

        // Byte-enable partial write
        req(2'b01, 5'd3, 3'd5, 3'd6, 8'h01, 64'h00000000000000FF, 53'h0, 2'b00, 1'b0, 1'b0);
        lookup(5'd3, 3'd5, 3'd0, 53'h1A);
        chk("be_data", bus.rdata_o, 64'h11223344556677FF);

        // Multi-way hit priority and miss
        req(2'b10, 5'd7, 3'd0, 3'd5, 8'h00, 64'h0, 53'h2C, 2'b01, 1'b0, 1'b0);
        req(2'b10, 5'd7, 3'd0, 3'd2, 8'h00, 64'h0, 53'h2C, 2'b10, 1'b0, 1'b0);
        lookup(5'd7, 3'd0, 3'd0, 53'h2C);
        chk("prio_hit",   64'(bus.hit_o),     64'd1);
        chk("prio_way",   64'(bus.hit_way_o), 64'd2);
        chk("prio_state", 64'(bus.state_o),   64'd2);
        lookup(5'd7, 3'd0, 3'd4, 53'h1B);
        chk("miss_hit",   64'(bus.hit_o),     64'd0);
        chk("miss_way",   64'(bus.hit_way_o), 64'd4);
        chk("miss_state", 64'(bus.state_o),   64'd0);

        // Flush walk with a repeat pulse mid-walk
        flush_pulse();
        chk("flush_busy", 64'(bus.flush_busy_o), 64'd1);
        wait_walk(1'b1, bc);
        chk("flush_len", 64'(bc), 64'd32);
        chk("flush_ready_after", 64'(bus.req_ready_o), 64'd1);
        lookup(5'd3, 3'd5, 3'd6, 53'h1A);
        chk("fl_miss3",  64'(bus.hit_o),   64'd0);
        chk("fl_data3",  bus.rdata_o,      64'h11223344556677FF);
        chk("fl_state3", 64'(bus.state_o), 64'd0);
        lookup(5'd7, 3'd0, 3'd2, 53'h2C);
        chk("fl_miss7",  64'(bus.hit_o),   64'd0);

        // Request and flush in the same IDLE cycle: request accepted, walk starts
        req(2'b11, 5'd9, 3'd1, 3'd3, 8'hFF, 64'hCAFEF00DDEADBEEF, 53'h55, 2'b11, 1'b0, 1'b1);
        chk("req_flush_busy", 64'(bus.flush_busy_o), 64'd1);
        wait_walk(1'b0, bc);
        chk("req_flush_len", 64'(bc), 64'd32);
        lookup(5'd9, 3'd1, 3'd3, 53'h55);
        chk("req_flush_miss", 64'(bus.hit_o), 64'd0);
        chk("req_flush_data", bus.rdata_o,    64'hCAFEF00DDEADBEEF);

`ifdef L1_SRAM_BANK_PARITY_EN
        req(2'b01, 5'd4, 3'd2, 3'd1, 8'hFF, 64'h0123456789ABCDEF, 53'h0, 2'b00, 1'b1, 1'b0);
        lookup(5'd4, 3'd2, 3'd1, 53'h77);
        chk("par_err_set", 64'(bus.parity_err_o), 64'd1);
        req(2'b01, 5'd4, 3'd2, 3'd1, 8'hFF, 64'h0123456789ABCDEF, 53'h0, 2'b00, 1'b0, 1'b0);
        lookup(5'd4, 3'd2, 3'd1, 53'h77);
        chk("par_err_clr", 64'(bus.parity_err_o), 64'd0);
`else
        req(2'b01, 5'd4, 3'd2, 3'd1, 8'hFF, 64'h0123456789ABCDEF, 53'h0, 2'b00, 1'b1, 1'b0);
        lookup(5'd4, 3'd2, 3'd1, 53'h77);
        chk("nopar_err", 64'(bus.parity_err_o), 64'd0);
        chk("nopar_data", bus.rdata_o, 64'h0123456789ABCDEF);
`endif

        // Reset in the middle of a walk
        req(2'b10, 5'd0,  3'd0, 3'd0, 8'h00, 64'h0, 53'h10, 2'b11, 1'b0, 1'b0);
        req(2'b10, 5'd31, 3'd0, 3'd7, 8'h00, 64'h0, 53'h11, 2'b01, 1'b0, 1'b0);
        lookup(5'd31, 3'd0, 3'd0, 53'h11);
        chk("pre_rst_hit", 64'(bus.hit_o), 64'd1);
        flush_pulse();
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_walk_busy",  64'(bus.flush_busy_o), 64'd0);
        chk("rst_walk_ready", 64'(bus.req_ready_o),  64'd1);
        chk("rst_walk_hit",   64'(bus.hit_o),        64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lookup(5'd0, 3'd0, 3'd0, 53'h10);
        chk("rst_miss0",  64'(bus.hit_o), 64'd0);
        lookup(5'd31, 3'd0, 3'd7, 53'h11);
        chk("rst_miss31", 64'(bus.hit_o), 64'd0);
        lookup(5'd9, 3'd1, 3'd3, 53'h55);
        chk("rst_miss9",  64'(bus.hit_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rv64g_l1_sram_bank_p.md
RV64G_L1_SRAM_BANK_P -- requirements
Module: rv64g_l1_sram_bank_p

Interface
REQ-001 Parameters SHALL be: SETS 32 (sets/bank); WAYS 8 (ways); WORDS_PER_LINE 8 (words/line); DATA_W 64 (word width, multiple of 8); TAG_W 53 (tag width); INDEX_W 5 (log2 SETS); WORD_W 3 (log2 WORDS_PER_LINE); WAY_W 3 (log2 WAYS).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Port clk_i SHALL be an input, 1 bit: clock.
REQ-004 Port rst_ni SHALL be an input, 1 bit: async active-low reset.
REQ-005 Port req_valid_i SHALL be an input, 1 bit: request valid.
REQ-006 Port req_ready_o SHALL be an output, 1 bit: bank can accept.
REQ-007 Port req_op_i SHALL be an input, 2 bits: 00 lookup/read, 01 data write, 10 tag+state write, 11 data+tag+state write.
REQ-008 Ports index_i (INDEX_W), word_i (WORD_W) and way_i (WAY_W) SHALL be inputs: set, word, and way for writes/selected read.
REQ-009 Ports be_i (DATA_W/8) and wdata_i (DATA_W) SHALL be inputs: byte enables and write data.
REQ-010 Ports tag_i (TAG_W) and state_i (2) SHALL be inputs: tag and MESI state to write.
REQ-011 Port lookup_tag_i SHALL be an input, TAG_W bits: tag compared on lookup.
REQ-012 Port err_inject_i SHALL be an input, 1 bit: flip stored parity of byte 0 on this data write.
REQ-013 Port flush_i SHALL be an input, 1 bit: start invalidate-all walk.
REQ-014 Port flush_busy_o SHALL be an output, 1 bit: walk in progress.
REQ-015 Ports rsp_valid_o (1), hit_o (1), hit_way_o (WAY_W), rdata_o (DATA_W), state_o (2) and parity_err_o (1) SHALL be outputs: lookup response.

Function
REQ-016 A request SHALL be accepted when req_valid_i && req_ready_o at a rising edge.
REQ-017 req_ready_o SHALL be 0 while flush_busy_o=1 and 1 otherwise.
REQ-018 Lookup latency SHALL be exactly 1 cycle: rsp_valid_o=1 for one cycle after an accepted op 00, else 0.
REQ-019 Lookup hit SHALL be state!=MESI_N(00) && tag==lookup_tag_i per way; hit_way_o = lowest matching way; hit_o=0 gives hit_way_o=way_i.
REQ-020 rdata_o and state_o SHALL come from hit_way_o (or way_i on miss), sampled at acceptance.
REQ-021 Response registers SHALL hold their value until the next accepted lookup.
REQ-022 Data writes SHALL update only bytes with be_i=1 at {index_i,word_i} of way_i; tag writes SHALL update tag and state of way_i at index_i.
REQ-023 A lookup accepted the cycle after a write SHALL observe the written values, with no stale read.
REQ-024 The flush FSM SHALL have states IDLE and WALK; flush_i in IDLE moves to WALK with counter=0, and each WALK cycle sets state of all WAYS at set[counter] to MESI_N; after counter==SETS-1 it returns to IDLE (SETS cycles busy).
REQ-025 flush_i while in WALK SHALL be ignored.
REQ-026 flush_i with req_valid_i in the same IDLE cycle SHALL accept the request, then start the walk the same edge.
REQ-027 Flush SHALL leave data and tags untouched.

Reset
REQ-028 On rst_ni=0, all state entries SHALL be MESI_N, the FSM IDLE, counter 0, rsp_valid_o/hit_o/parity_err_o 0, rdata_o/state_o/hit_way_o 0, and req_ready_o 1 after release.
REQ-029 Reset mid-walk SHALL abort the walk, and all states SHALL be invalid anyway.

Configuration
REQ-030 With L1_SRAM_BANK_PARITY_EN defined, one even-parity bit SHALL be stored per data byte, written with enabled bytes; err_inject_i inverts byte 0's stored bit; parity_err_o=1 with rsp_valid_o if any byte of the selected word mismatches.
REQ-031 Without L1_SRAM_BANK_PARITY_EN, there SHALL be no parity storage, parity_err_o SHALL be constant 0, and err_inject_i SHALL be ignored.

Verification
REQ-032 Write op 11 (index 3, word 5, way 6, be FF, data 0x1122334455667788, tag 0x1A, state 11), then lookup tag 0x1A -> next cycle hit_o=1, hit_way_o=6, rdata 0x1122334455667788, state 11.
REQ-033 Write be 0x01, data 0xFF to the same word -> lookup returns 0x11223344556677FF.
REQ-034 Same tag written valid in ways 2 and 5 -> hit_way_o=2; lookup tag 0x1B -> hit_o=0.
REQ-035 flush_i pulse -> flush_busy_o=1 and req_ready_o=0 for exactly 32 cycles, then all lookups miss and data is unchanged via state 00; a second flush_i mid-walk does not extend it.
REQ-036 With parity: write with err_inject_i=1, then lookup -> parity_err_o=1; rewrite with err_inject_i=0 -> parity_err_o=0.
REQ-037 Assert rst_ni=0 at walk cycle 10 -> flush_busy_o=0 immediately, and all sets miss after release.
